// File: rtl/signed_dot_accumulator.sv
// Signed dot-product accumulator behind the array multiplier's product port.
// Define SIGNED_DOT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module signed_dot_accumulator #(
    parameter int N = 4,
    parameter int ACC_W = 2*N+4,
    parameter int LEN = 4,
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CW-1:0]    count
);

    localparam int MSB = ACC_W - 1;

`ifdef SIGNED_DOT_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic {ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first;
    logic             last;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] next;
    logic             add_ovf;

    assign in_ready  = (state_q == ACC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign count     = count_q;

    always_comb begin
        accept  = in_valid & in_ready;
        first   = (count_q == '0);
        last    = (count_q == CW'(LEN-1));
        addend  = ACC_W'($signed(prod));
        sum     = acc_q + addend;
        // The first product of a dot product replaces acc, so it cannot overflow.
        add_ovf = !first
                  && (acc_q[MSB] == addend[MSB])
                  && (sum[MSB] != acc_q[MSB]);
        next    = first ? addend : sum;
`ifdef SIGNED_DOT_ACC_SAT_EN
        if (add_ovf) begin
            next = acc_q[MSB] ? SMIN : SMAX;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        ovf_sticky_d = ovf_sticky_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;

        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (last) begin
                        out_data_d   = next;
                        out_ovf_d    = ovf_sticky_q | add_ovf;
                        out_valid_d  = 1'b1;
                        acc_d        = '0;
                        count_d      = '0;
                        ovf_sticky_d = 1'b0;
                        state_d      = OUT;
                    end else begin
                        acc_d        = next;
                        count_d      = count_q + CW'(1);
                        ovf_sticky_d = ovf_sticky_q | add_ovf;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase

        // Soft clear wins over any handshake; the last result is kept but invalid.
        if (clr) begin
            state_d      = ACC;
            acc_d        = '0;
            count_d      = '0;
            ovf_sticky_d = 1'b0;
            out_valid_d  = 1'b0;
            out_data_d   = out_data_q;
            out_ovf_d    = out_ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACC;
            acc_q        <= '0;
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_sticky_q <= ovf_sticky_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_signed_dot_accumulator.sv
// Directed bench for signed_dot_accumulator: 10-bit, 8-bit and LEN=1 builds.
// Expected values for the 8-bit build follow SIGNED_DOT_ACC_SAT_EN.
module tb_signed_dot_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] prod;
    logic       out_ready;

    logic       ir_a, ov_a, of_a;
    logic [9:0] od_a;
    logic [1:0] cnt_a;
    logic       ir_b, ov_b, of_b;
    logic [7:0] od_b;
    logic [1:0] cnt_b;
    logic       ir_c, ov_c, of_c;
    logic [7:0] od_c;
    logic [0:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_dot_accumulator #(.N(4), .ACC_W(10), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(ir_a), .prod(prod),
        .out_valid(ov_a), .out_ready(out_ready),
        .out_data(od_a), .out_ovf(of_a), .count(cnt_a)
    );

    signed_dot_accumulator #(.N(4), .ACC_W(8), .LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(ir_b), .prod(prod),
        .out_valid(ov_b), .out_ready(out_ready),
        .out_data(od_b), .out_ovf(of_b), .count(cnt_b)
    );

    signed_dot_accumulator #(.N(4), .ACC_W(8), .LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(ir_c), .prod(prod),
        .out_valid(ov_c), .out_ready(out_ready),
        .out_data(od_c), .out_ovf(of_c), .count(cnt_c)
    );

    typedef struct {
        logic [3:0][7:0] p;
        logic [9:0]      ea;
        logic            ea_ovf;
        logic [7:0]      eb;
        logic            eb_ovf;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        prod     = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        vt[0] = '{p: {8'h03, 8'h14, 8'hF4, 8'h06},
                  ea: 10'h011, ea_ovf: 1'b0, eb: 8'h11, eb_ovf: 1'b0};
        vt[2] = '{p: {8'h04, 8'h03, 8'h02, 8'h01},
                  ea: 10'h00A, ea_ovf: 1'b0, eb: 8'h0A, eb_ovf: 1'b0};
`ifdef SIGNED_DOT_ACC_SAT_EN
        vt[1] = '{p: {4{8'h40}}, ea: 10'h100, ea_ovf: 1'b0,
                  eb: 8'h7F, eb_ovf: 1'b1};
        vt[3] = '{p: {4{8'hC0}}, ea: 10'h300, ea_ovf: 1'b0,
                  eb: 8'h80, eb_ovf: 1'b1};
        vt[4] = '{p: {4{8'h7F}}, ea: 10'h1FC, ea_ovf: 1'b0,
                  eb: 8'h7F, eb_ovf: 1'b1};
        vt[5] = '{p: {4{8'h80}}, ea: 10'h200, ea_ovf: 1'b0,
                  eb: 8'h80, eb_ovf: 1'b1};
`else
        vt[1] = '{p: {4{8'h40}}, ea: 10'h100, ea_ovf: 1'b0,
                  eb: 8'h00, eb_ovf: 1'b1};
        vt[3] = '{p: {4{8'hC0}}, ea: 10'h300, ea_ovf: 1'b0,
                  eb: 8'h00, eb_ovf: 1'b1};
        vt[4] = '{p: {4{8'h7F}}, ea: 10'h1FC, ea_ovf: 1'b0,
                  eb: 8'hFC, eb_ovf: 1'b1};
        vt[5] = '{p: {4{8'h80}}, ea: 10'h200, ea_ovf: 1'b0,
                  eb: 8'h00, eb_ovf: 1'b1};
`endif

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b1;
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_out_data", 32'(od_a), 32'd0);
        chk("rst_out_ovf", 32'(of_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_in_ready", 32'(ir_a), 32'd1);
        step();

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) send(vt[v].p[k]);
            chk($sformatf("v%0d_valid_a", v), 32'(ov_a), 32'd1);
            chk($sformatf("v%0d_data_a", v), 32'(od_a), 32'(vt[v].ea));
            chk($sformatf("v%0d_ovf_a", v), 32'(of_a), 32'(vt[v].ea_ovf));
            chk($sformatf("v%0d_valid_b", v), 32'(ov_b), 32'd1);
            chk($sformatf("v%0d_data_b", v), 32'(od_b), 32'(vt[v].eb));
            chk($sformatf("v%0d_ovf_b", v), 32'(of_b), 32'(vt[v].eb_ovf));
            chk($sformatf("v%0d_ready_busy", v), 32'(ir_a), 32'd0);
            step();
            chk($sformatf("v%0d_valid_drop", v), 32'(ov_a), 32'd0);
            chk($sformatf("v%0d_ready_back", v), 32'(ir_a), 32'd1);
        end

        for (int k = 0; k < 4; k++) send(vt[0].p[k]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        prod      = 8'h7F;
        chk("bp_first", 32'(od_a), 32'h011);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp%0d_valid", i), 32'(ov_a), 32'd1);
            chk($sformatf("bp%0d_data", i), 32'(od_a), 32'h011);
            chk($sformatf("bp%0d_ready", i), 32'(ir_a), 32'd0);
            chk($sformatf("bp%0d_count", i), 32'(cnt_a), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("bp_release", 32'(ov_a), 32'd0);
        for (int k = 0; k < 4; k++) send(8'h01);
        chk("bp_next_valid", 32'(ov_a), 32'd1);
        chk("bp_next_data", 32'(od_a), 32'h004);
        step();

        send(8'h05);
        send(8'h05);
        chk("clr_pre_count", 32'(cnt_a), 32'd2);
        clr      = 1'b1;
        in_valid = 1'b1;
        prod     = 8'h33;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", 32'(cnt_a), 32'd0);
        chk("clr_valid", 32'(ov_a), 32'd0);
        for (int k = 0; k < 4; k++) send(8'h02);
        chk("clr_after_valid", 32'(ov_a), 32'd1);
        chk("clr_after_data", 32'(od_a), 32'h008);
        out_ready = 1'b0;
        clr       = 1'b1;
        step();
        clr       = 1'b0;
        out_ready = 1'b1;
        chk("clr_out_valid", 32'(ov_a), 32'd0);
        chk("clr_out_ready", 32'(ir_a), 32'd1);
        chk("clr_out_hold", 32'(od_a), 32'h008);

        send(8'h05);
        send(8'h05);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov_a), 32'd0);
        chk("arst_data", 32'(od_a), 32'd0);
        chk("arst_ovf", 32'(of_a), 32'd0);
        chk("arst_count", 32'(cnt_a), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("arst_ready", 32'(ir_a), 32'd1);
        for (int k = 0; k < 4; k++) send(8'h02);
        chk("arst_after_valid", 32'(ov_a), 32'd1);
        chk("arst_after_data", 32'(od_a), 32'h008);
        step();

        clr = 1'b1;
        step();
        clr = 1'b0;
        send(8'hF4);
        chk("len1_valid", 32'(ov_c), 32'd1);
        chk("len1_data", 32'(od_c), 32'hF4);
        chk("len1_ovf", 32'(of_c), 32'd0);
        chk("len1_count", 32'(cnt_c), 32'd0);
        in_valid = 1'b1;
        prod     = 8'h05;
        step();
        chk("len1_drain", 32'(ov_c), 32'd0);
        step();
        in_valid = 1'b0;
        chk("len1_next_valid", 32'(ov_c), 32'd1);
        chk("len1_next_data", 32'(od_c), 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
